// File: rtl/pregfile_mp_if.sv
// Bundle of rename, CDB writeback and operand-read signals for the physical register file.
// The master side is the core pipeline; the slave side is pregfile_mp.
interface pregfile_mp_if #(
  parameter int NUM_PHYS_REG = 64,
  parameter int PREG_W       = $clog2(NUM_PHYS_REG),
  parameter int NUM_WB       = 4,
  parameter int NUM_RD       = 8,
  parameter int NUM_ALLOC    = 1
);
  logic                                flush;
  logic [NUM_ALLOC-1:0]                alloc_valid;
  logic [NUM_ALLOC-1:0][PREG_W-1:0]    alloc_preg;
  logic [NUM_WB-1:0]                   wb_valid;
  logic [NUM_WB-1:0][PREG_W-1:0]       wb_preg;
  logic [NUM_WB-1:0][31:0]             wb_data;
  logic [NUM_RD-1:0]                   rd_en;
  logic [NUM_RD-1:0][PREG_W-1:0]       rd_preg;
  logic [NUM_RD-1:0][31:0]             rd_data;
  logic [NUM_RD-1:0]                   rd_ready;

  modport master (
    output flush, alloc_valid, alloc_preg, wb_valid, wb_preg, wb_data, rd_en, rd_preg,
    input  rd_data, rd_ready
  );

  modport slave (
    input  flush, alloc_valid, alloc_preg, wb_valid, wb_preg, wb_data, rd_en, rd_preg,
    output rd_data, rd_ready
  );
endinterface

// File: rtl/pregfile_mp.sv
// Multi-ported physical register file with ready-bit scoreboard and CDB bypass on every read port.
// p0 is hardwired to zero and always ready.
module pregfile_mp #(
  parameter int NUM_PHYS_REG = 64,
  parameter int PREG_W       = $clog2(NUM_PHYS_REG),
  parameter int NUM_WB       = 4,
  parameter int NUM_RD       = 8,
  parameter int NUM_ALLOC    = 1
) (
  input logic           clk,
  input logic           rst,
  pregfile_mp_if.slave  bus
);

  logic [31:0] data_q  [NUM_PHYS_REG];
  logic [31:0] data_d  [NUM_PHYS_REG];
  logic        ready_q [NUM_PHYS_REG];
  logic        ready_d [NUM_PHYS_REG];

  logic [NUM_RD-1:0][31:0] rd_data_c;
  logic [NUM_RD-1:0]       rd_ready_c;

  // Ports are walked highest-first so the lowest-indexed writer lands last and wins.
  // Allocation is applied after writeback because it is the newer event for that preg.
  always_comb begin
    for (int r = 0; r < NUM_PHYS_REG; r++) begin
      data_d[r]  = data_q[r];
      ready_d[r] = ready_q[r];
    end
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      if (bus.wb_valid[i] && (bus.wb_preg[i] != '0)) begin
        data_d[bus.wb_preg[i]]  = bus.wb_data[i];
        ready_d[bus.wb_preg[i]] = 1'b1;
      end
    end
    if (bus.flush) begin
      for (int r = 0; r < NUM_PHYS_REG; r++) begin
        ready_d[r] = 1'b1;
      end
    end else begin
      for (int j = 0; j < NUM_ALLOC; j++) begin
        if (bus.alloc_valid[j] && (bus.alloc_preg[j] != '0)) begin
          ready_d[bus.alloc_preg[j]] = 1'b0;
        end
      end
    end
    data_d[0]  = '0;
    ready_d[0] = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < NUM_PHYS_REG; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q[gi]  <= '0;
          ready_q[gi] <= 1'b1;
        end else begin
          data_q[gi]  <= data_d[gi];
          ready_q[gi] <= ready_d[gi];
        end
      end
    end
  endgenerate

  // Read ports: array value by default, overridden by the lowest matching CDB port.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_c[k]  = '0;
      rd_ready_c[k] = 1'b0;
      if (bus.rd_en[k]) begin
        if (bus.rd_preg[k] == '0) begin
          rd_ready_c[k] = 1'b1;
        end else begin
          rd_data_c[k]  = data_q[bus.rd_preg[k]];
          rd_ready_c[k] = ready_q[bus.rd_preg[k]];
          for (int i = NUM_WB - 1; i >= 0; i--) begin
            if (bus.wb_valid[i] && (bus.wb_preg[i] == bus.rd_preg[k])) begin
              rd_data_c[k]  = bus.wb_data[i];
              rd_ready_c[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_ready = rd_ready_c;

  // Two CDB ports hitting the same preg in one cycle is an upstream protocol violation.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WB; i++) begin
        for (int j = i + 1; j < NUM_WB; j++) begin
          assert (!(bus.wb_valid[i] && bus.wb_valid[j] && (bus.wb_preg[i] != '0) &&
                    (bus.wb_preg[i] == bus.wb_preg[j])))
            else $warning("pregfile_mp: wb collision on preg %0d (ports %0d and %0d)",
                          bus.wb_preg[i], i, j);
        end
      end
    end
  end

endmodule

// File: tb/tb_pregfile_mp.sv
// Directed bench for pregfile_mp: a per-cycle reference model compared on every read port,
// plus literal expectations taken from the register file's documented behaviour.
module tb_pregfile_mp;
  localparam int NPR = 64;
  localparam int PW  = 6;
  localparam int NWB = 4;
  localparam int NRD = 8;
  localparam int NAL = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pregfile_mp_if #(.NUM_PHYS_REG(NPR), .PREG_W(PW), .NUM_WB(NWB), .NUM_RD(NRD), .NUM_ALLOC(NAL)) bus ();

  pregfile_mp #(.NUM_PHYS_REG(NPR), .PREG_W(PW), .NUM_WB(NWB), .NUM_RD(NRD), .NUM_ALLOC(NAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state: what each preg holds and whether its value has been produced.
  logic [31:0] m_data  [NPR];
  bit          m_ready [NPR];
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NPR; r++) begin
        m_data[r]  = 32'h0;
        m_ready[r] = 1'b1;
      end
      m_valid = 1'b1;
    end else begin
      for (int r = 1; r < NPR; r++) begin
        bit written;
        bit allocated;
        written   = 1'b0;
        allocated = 1'b0;
        for (int i = 0; i < NWB; i++) begin
          if (!written && bus.wb_valid[i] && int'(bus.wb_preg[i]) == r) begin
            m_data[r] = bus.wb_data[i];
            written   = 1'b1;
          end
        end
        for (int j = 0; j < NAL; j++)
          if (bus.alloc_valid[j] && int'(bus.alloc_preg[j]) == r) allocated = 1'b1;
        if (bus.flush)       m_ready[r] = 1'b1;
        else if (allocated)  m_ready[r] = 1'b0;
        else if (written)    m_ready[r] = 1'b1;
      end
    end
  end

  task automatic model_read(input int k, output logic [31:0] d, output logic r);
    int p;
    p = int'(bus.rd_preg[k]);
    d = 32'h0;
    r = 1'b0;
    if (bus.rd_en[k]) begin
      if (p == 0) begin
        r = 1'b1;
      end else begin
        d = m_data[p];
        r = m_ready[p];
        for (int i = NWB - 1; i >= 0; i--) begin
          if (bus.wb_valid[i] && int'(bus.wb_preg[i]) == p) begin
            d = bus.wb_data[i];
            r = 1'b1;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < NRD; k++) begin
        logic [31:0] ed;
        logic        er;
        model_read(k, ed, er);
        checks++;
        if (bus.rd_data[k] !== ed || bus.rd_ready[k] !== er) begin
          failures++;
          $display("FAIL model_port%0d t=%0t preg=%0d got data=%h ready=%b expected data=%h ready=%b",
                   k, $time, bus.rd_preg[k], bus.rd_data[k], bus.rd_ready[k], ed, er);
        end
      end
    end
  end

  task automatic expect_lit(input string name, input int k, input logic [31:0] d, input logic r);
    checks++;
    if (bus.rd_data[k] !== d || bus.rd_ready[k] !== r) begin
      failures++;
      $display("FAIL %s port%0d got data=%h ready=%b expected data=%h ready=%b",
               name, k, bus.rd_data[k], bus.rd_ready[k], d, r);
    end else begin
      $display("ok   %s port%0d data=%h ready=%b", name, k, d, r);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.flush       = 1'b0;
    bus.alloc_valid = '0;
    bus.wb_valid    = '0;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.alloc_valid = '0;
    bus.alloc_preg  = '0;
    bus.wb_valid    = '0;
    bus.wb_preg     = '0;
    bus.wb_data     = '0;
    bus.rd_en       = '0;
    bus.rd_preg     = '0;
    repeat (2) next_cycle();
    rst = 1'b0;

    // Reset state on every port, p5 and p0 alternating.
    bus.rd_en = '1;
    for (int k = 0; k < NRD; k++) bus.rd_preg[k] = (k % 2 == 0) ? 6'd5 : 6'd0;
    sample();
    expect_lit("reset_p5", 0, 32'h0, 1'b1);
    expect_lit("reset_p0", 1, 32'h0, 1'b1);
    expect_lit("reset_p5", 6, 32'h0, 1'b1);

    // Writes to p0 are ignored, including on the bypass path.
    next_cycle();
    bus.wb_valid[0] = 1'b1; bus.wb_preg[0] = 6'd0; bus.wb_data[0] = 32'hDEAD;
    bus.rd_preg = '0;
    sample();
    expect_lit("p0_bypass", 0, 32'h0, 1'b1);
    next_cycle();
    sample();
    expect_lit("p0_after_wr", 3, 32'h0, 1'b1);

    // Allocate p7: no bypass of the not-ready state, then not ready next cycle.
    next_cycle();
    bus.alloc_valid[0] = 1'b1; bus.alloc_preg[0] = 6'd7; bus.rd_preg[0] = 6'd7;
    sample();
    expect_lit("alloc_no_bypass", 0, 32'h0, 1'b1);
    next_cycle();
    sample();
    expect_lit("alloc_notready", 0, 32'h0, 1'b0);
    next_cycle();
    bus.wb_valid[2] = 1'b1; bus.wb_preg[2] = 6'd7; bus.wb_data[2] = 32'h1234;
    sample();
    expect_lit("bypass_p7", 0, 32'h1234, 1'b1);
    next_cycle();
    sample();
    expect_lit("array_p7", 0, 32'h1234, 1'b1);

    // Four parallel writebacks, read back on all eight ports.
    next_cycle();
    for (int i = 0; i < NWB; i++) begin
      bus.wb_valid[i] = 1'b1;
      bus.wb_preg[i]  = 6'(9 + i);
      bus.wb_data[i]  = 32'(32'hA + i);
    end
    for (int k = 0; k < NRD; k++) bus.rd_preg[k] = 6'(9 + k % 4);
    sample();
    expect_lit("quad_bypass", 0, 32'hA, 1'b1);
    expect_lit("quad_bypass", 3, 32'hD, 1'b1);
    next_cycle();
    sample();
    for (int k = 0; k < NRD; k++) expect_lit("quad_array", k, 32'(32'hA + k % 4), 1'b1);

    // Collision on p20: lowest port (1) wins both on bypass and in the array.
    next_cycle();
    bus.wb_valid[1] = 1'b1; bus.wb_preg[1] = 6'd20; bus.wb_data[1] = 32'h11;
    bus.wb_valid[3] = 1'b1; bus.wb_preg[3] = 6'd20; bus.wb_data[3] = 32'h33;
    bus.rd_preg[0] = 6'd20;
    sample();
    expect_lit("collide_bypass", 0, 32'h11, 1'b1);
    next_cycle();
    sample();
    expect_lit("collide_array", 0, 32'h11, 1'b1);

    // Same-cycle alloc and writeback: data written, ready ends low.
    next_cycle();
    bus.alloc_valid[0] = 1'b1; bus.alloc_preg[0] = 6'd30;
    bus.wb_valid[0] = 1'b1; bus.wb_preg[0] = 6'd30; bus.wb_data[0] = 32'h55;
    bus.rd_preg[1] = 6'd30;
    sample();
    expect_lit("alloc_wb_bypass", 1, 32'h55, 1'b1);
    next_cycle();
    sample();
    expect_lit("alloc_wb_after", 1, 32'h55, 1'b0);

    // Allocations squashed and overridden by flush.
    next_cycle();
    bus.alloc_valid[0] = 1'b1; bus.alloc_preg[0] = 6'd40;
    bus.wb_valid[0] = 1'b1; bus.wb_preg[0] = 6'd41; bus.wb_data[0] = 32'h77;
    bus.rd_preg[2] = 6'd40; bus.rd_preg[3] = 6'd41; bus.rd_preg[4] = 6'd42;
    next_cycle();
    bus.alloc_valid[0] = 1'b1; bus.alloc_preg[0] = 6'd41;
    sample();
    expect_lit("pre_flush_p40", 2, 32'h0, 1'b0);
    expect_lit("pre_flush_p41", 3, 32'h77, 1'b1);
    next_cycle();
    bus.flush = 1'b1; bus.alloc_valid[0] = 1'b1; bus.alloc_preg[0] = 6'd42;
    sample();
    expect_lit("flush_cyc_p41", 3, 32'h77, 1'b0);
    expect_lit("flush_cyc_p42", 4, 32'h0, 1'b1);
    next_cycle();
    sample();
    expect_lit("post_flush_p40", 2, 32'h0, 1'b1);
    expect_lit("post_flush_p41", 3, 32'h77, 1'b1);
    expect_lit("post_flush_p42", 4, 32'h0, 1'b1);

    // Mixed traffic checked by the model only; writeback targets kept distinct.
    for (int n = 0; n < 40; n++) begin
      int base;
      next_cycle();
      base = $urandom_range(0, NPR - 1);
      for (int i = 0; i < NWB; i++) begin
        bus.wb_valid[i] = 1'($urandom_range(0, 1));
        bus.wb_preg[i]  = 6'((base + i * 16) % NPR);
        bus.wb_data[i]  = $urandom;
      end
      bus.alloc_valid[0] = 1'($urandom_range(0, 1));
      bus.alloc_preg[0]  = 6'($urandom_range(0, NPR - 1));
      bus.flush          = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < NRD; k++) begin
        bus.rd_en[k]   = ($urandom_range(0, 7) != 0);
        bus.rd_preg[k] = (k < 2) ? bus.wb_preg[k] : 6'($urandom_range(0, NPR - 1));
      end
      sample();
      $display("mix  cycle=%0d wb_valid=%b alloc=%b/%0d flush=%b", n, bus.wb_valid,
               bus.alloc_valid, bus.alloc_preg[0], bus.flush);
    end

    // Reset mid-stream discards in-flight traffic and clears all data.
    next_cycle();
    rst = 1'b1;
    bus.wb_valid[0] = 1'b1; bus.wb_preg[0] = 6'd9; bus.wb_data[0] = 32'hFFFF;
    bus.alloc_valid[0] = 1'b1; bus.alloc_preg[0] = 6'd10;
    next_cycle();
    rst = 1'b0;
    bus.rd_en = '1;
    bus.rd_preg = '0;
    bus.rd_preg[0] = 6'd9; bus.rd_preg[1] = 6'd41; bus.rd_preg[2] = 6'd10; bus.rd_preg[3] = 6'd7;
    sample();
    expect_lit("rst_p9", 0, 32'h0, 1'b1);
    expect_lit("rst_p41", 1, 32'h0, 1'b1);
    expect_lit("rst_p10", 2, 32'h0, 1'b1);
    expect_lit("rst_p7", 3, 32'h0, 1'b1);

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pregfile_mp.md
# pregfile_mp

Multi-ported physical register file with an integrated ready-bit scoreboard for the out-of-order core. It accepts NUM_WB parallel CDB writebacks per cycle and serves NUM_RD independent combinational read ports, one pair per reservation-station issue slot. Every read port forwards same-cycle CDB data and reports a per-operand ready flag. Rename allocation clears ready bits, and flush recovery sets them all again.

## Interface
- NUM_PHYS_REG, 64: number of physical registers; power of two, at least 32.
- PREG_W, $clog2(NUM_PHYS_REG): width of a physical register index.
- NUM_WB, 4: number of CDB writeback ports.
- NUM_RD, 8: number of read ports.
- NUM_ALLOC, 1: number of rename allocations per cycle.
- clk, in, 1: clock.
- rst, in, 1: reset; synchronous, active-high.
- flush, in, 1: mispredict recovery; sets every ready bit.
- alloc_valid, in, NUM_ALLOC: rename allocates a destination preg.
- alloc_preg, in, NUM_ALLOC x PREG_W: index of the allocated preg.
- wb_valid, in, NUM_WB: CDB writeback valid.
- wb_preg, in, NUM_WB x PREG_W: writeback destination index.
- wb_data, in, NUM_WB x 32: writeback value.
- rd_en, in, NUM_RD: read port enable.
- rd_preg, in, NUM_RD x PREG_W: read index.
- rd_data, out, NUM_RD x 32: read value.
- rd_ready, out, NUM_RD: operand available this cycle.

## Operation
- Storage: data[NUM_PHYS_REG] x 32 and ready[NUM_PHYS_REG].
- p0 is hardwired: it reads 0 and is always ready. Writes and allocations to p0 are ignored.
- Writeback: each wb_valid[i] with wb_preg[i] != 0 writes data and sets ready at the next edge.
- Writeback collision: if several ports target the same preg in one cycle, the lowest-indexed port wins. This is a protocol violation and is flagged by a simulation-only assertion.
- Allocation: each alloc_valid[j] with alloc_preg[j] != 0 clears ready at the next edge. Data is left untouched.
- Allocate and writeback of the same preg in the same cycle: data is written, and the ready bit ends at 0 (allocation is the newer event).
- Flush: sets every ready bit to 1 at the next edge; data is preserved. All same-cycle allocations are squashed. Same-cycle writebacks still write data.
- Read path (combinational), for each port k:
  - rd_en[k] = 0: rd_data = 0 and rd_ready = 0.
  - rd_preg[k] = 0: rd_data = 0 and rd_ready = 1.
  - Otherwise, if any wb_valid[i] matches rd_preg[k], rd_data = wb_data of the lowest matching port and rd_ready = 1. This is CDB bypass.
  - Otherwise, rd_data = data[rd_preg[k]] and rd_ready = ready[rd_preg[k]].
- Allocation does not bypass: a preg allocated this cycle still reads its old ready bit until the next edge.
- Indices are unsigned; no wrap-around occurs because PREG_W covers the array exactly.

## Timing
- Reset, at the rst edge: all data = 0 and all ready = 1. rst has priority over flush, alloc and wb.
- Outputs during and after reset: rd_data = 0 and rd_ready follows the read rules (all pregs ready).
- Read latency is 0 cycles, combinational from rd_preg, rd_en, wb_* and state.
- Write-to-read latency is 0 cycles via bypass; the value is visible from the array 1 cycle later.
- Allocation-to-not-ready latency is 1 cycle.
- Flush takes effect in 1 cycle. All ready bits are 1 in the cycle after flush, regardless of same-cycle alloc.
- rst asserted mid-operation clears state at that edge; any in-flight wb or alloc in that cycle is discarded.
- Critical path: NUM_WB-way compare plus priority mux per read port. There is no internal pipelining.

## Test plan
- Reset, then read p5 and p0 on every port -> rd_data = 0, rd_ready = 1 on all ports. Write p0 = 0xDEAD -> p0 still reads 0.
- Allocate p7; next cycle read p7 -> rd_ready = 0. Write wb port 2 to p7 = 0x1234 and read p7 in the same cycle -> rd_data = 0x1234, rd_ready = 1 (bypass). Next cycle, with no wb -> array returns 0x1234, ready = 1.
- Four ports write p9..p12 = 0xA..0xD in one cycle; all 8 read ports read them next cycle -> exact values, all ready.
- wb ports 1 and 3 both write p20 (0x11 and 0x33) -> bypass and array both hold 0x11; assertion fires.
- Allocate p30 and write p30 = 0x55 in the same cycle -> next cycle data = 0x55, rd_ready = 0.
- Allocate p40 and p41, then flush with alloc p42 in the flush cycle -> next cycle p40, p41 and p42 are all ready and their data is unchanged. Assert rst mid-stream -> all data reads 0.
